// File: rtl/src_edge_reader.sv
// Walks a source vertex's edge list one record at a time: read request the cycle after accept, output the cycle after the response.
// One read outstanding; mem_req_ready/out_ready low hold the request/record stable, and in_ready is only high when idle.
module src_edge_reader #(
  parameter int ADDR_W      = 64,
  parameter int CNT_W       = 32,
  parameter int EDGE_STRIDE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_vertex_id,
  input  logic [63:0]       in_vertex_data,
  input  logic [ADDR_W-1:0] in_edge_addr,
  input  logic [CNT_W-1:0]  in_num_edges,
  input  logic              in_last_vertex,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rsp_dst_id,
  input  logic [63:0]       mem_rsp_edge_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_vertex_id,
  output logic [63:0]       out_vertex_data,
  output logic [63:0]       out_dst_id,
  output logic [63:0]       out_edge_data,
  output logic [CNT_W-1:0]  out_edge_id,
  output logic              out_last_edge,
  output logic              out_last_vertex,
  output logic              out_edges_empty
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] EMPTY = 3'd4;

  logic [2:0]        state;
  logic [63:0]       vid_q;
  logic [63:0]       vdata_q;
  logic [63:0]       dst_q;
  logic [63:0]       edata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  idx_q;
  logic              lv_q;
  logic              last_edge;

  // idx never passes num_edges-1, so an all-ones edge count cannot wrap it.
  assign last_edge = (idx_q == num_q - CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      vid_q   <= '0;
      vdata_q <= '0;
      dst_q   <= '0;
      edata_q <= '0;
      addr_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      lv_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vid_q   <= in_vertex_id;
            vdata_q <= in_vertex_data;
            addr_q  <= in_edge_addr;
            num_q   <= in_num_edges;
            lv_q    <= in_last_vertex;
            idx_q   <= '0;
            dst_q   <= '0;
            edata_q <= '0;
            state   <= (in_num_edges != '0) ? REQ : EMPTY;
          end
        end
        REQ: begin
          if (mem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            dst_q   <= mem_rsp_dst_id;
            edata_q <= mem_rsp_edge_data;
            state   <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (last_edge) begin
              state <= IDLE;
            end else begin
              idx_q  <= idx_q + CNT_W'(1);
              addr_q <= addr_q + ADDR_W'(EDGE_STRIDE);
              state  <= REQ;
            end
          end
        end
        EMPTY: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready        = (state == IDLE);
  assign mem_req_valid   = (state == REQ);
  assign mem_req_addr    = addr_q;
  assign out_valid       = (state == SEND) || (state == EMPTY);
  assign out_vertex_id   = vid_q;
  assign out_vertex_data = vdata_q;
  assign out_dst_id      = dst_q;
  assign out_edge_data   = edata_q;
  assign out_edge_id     = idx_q;
  assign out_edges_empty = (state == EMPTY);
  assign out_last_edge   = (state == EMPTY) || ((state == SEND) && last_edge);
  assign out_last_vertex = lv_q && out_last_edge;

endmodule

// File: doc/src_edge_reader.md
SRC_EDGE_READER -- requirements
Module: src_edge_reader

Interface
- REQ-001: Parameters SHALL be, one per line:
  - ADDR_W, 64, address width
  - CNT_W, 32, edge-count width
  - EDGE_STRIDE, 16, bytes per edge record
- REQ-002: clk  input  1  single clock; all state changes on its rising edge.
- REQ-003: reset  input  1  asynchronous, active-low; 0 resets all state immediately.
- REQ-004: in_valid/in_ready  input/output  1/1  vertex handshake; transfer when both are 1 on a clk edge.
- REQ-005: in_vertex_id, in_vertex_data  input  64 each  source vertex id and property.
- REQ-006: in_edge_addr  input  ADDR_W  byte address of the vertex's first edge record.
- REQ-007: in_num_edges  input  CNT_W  edge count of the vertex.
- REQ-008: in_last_vertex  input  1  vertex is the last of the iteration.
- REQ-009: mem_req_valid/mem_req_ready  output/input  1/1  read-request handshake.
- REQ-010: mem_req_addr  output  ADDR_W  edge record address.
- REQ-011: mem_rsp_valid  input  1  response strobe; no back-pressure.
- REQ-012: mem_rsp_dst_id, mem_rsp_edge_data  input  64 each  response payload.
- REQ-013: out_valid/out_ready  output/input  1/1  per-edge output handshake.
- REQ-014: out_vertex_id, out_vertex_data, out_dst_id, out_edge_data  output  64 each  per-edge record.
- REQ-015: out_edge_id  output  CNT_W  0-based edge index within the vertex.
- REQ-016: out_last_edge, out_last_vertex, out_edges_empty  output  1 each  record flags.

Function
- REQ-017: FSM states SHALL be IDLE, REQ, WAIT, SEND, EMPTY.
- REQ-018: in_ready SHALL be 1 only in IDLE.
- REQ-019: On an input transfer the block SHALL latch all in_* fields, clear the edge index to 0, and go to REQ if in_num_edges>0, else to EMPTY.
- REQ-020: In REQ, mem_req_valid=1 and mem_req_addr=edge_addr+idx*EDGE_STRIDE (mod 2^ADDR_W); the block SHALL go to WAIT when mem_req_ready=1, otherwise hold REQ with address stable.
- REQ-021: At most one read SHALL be outstanding.
- REQ-022: In WAIT, the first mem_rsp_valid SHALL latch dst_id and edge_data and go to SEND.
- REQ-023: mem_rsp_valid in any state other than WAIT SHALL be ignored.
- REQ-024: In SEND, out_valid=1 with out_edge_id=idx, out_last_edge=(idx==num_edges-1), out_last_vertex=latched last_vertex AND out_last_edge, out_edges_empty=0.
- REQ-025: In SEND, when out_ready=1: go to IDLE if last edge, else increment idx and go to REQ; with out_ready=0, all out_* SHALL hold stable.
- REQ-026: In EMPTY, out_valid=1 with out_edges_empty=1, out_last_edge=1, out_dst_id=0, out_edge_data=0, out_edge_id=0, out_last_vertex=latched last_vertex; go to IDLE on out_ready=1.
- REQ-027: Minimum latency SHALL be input transfer at edge N, mem_req_valid during cycle N+1, and out_valid the cycle after the response is sampled.
- REQ-028: Steady-state throughput SHALL be 1 edge per 3 cycles when memory answers in 1 cycle and out_ready=1.
- REQ-029: in_num_edges = 2^CNT_W-1 SHALL be handled without idx overflow, because idx stops at num_edges-1.
- REQ-030: Output payload SHALL be registered; outputs SHALL NOT be combinational paths from inputs.

Reset
- REQ-031: On reset=0 the FSM SHALL go to IDLE, and in_ready SHALL be 1 once reset=1.
- REQ-032: On reset=0 the following outputs SHALL be 0: mem_req_valid, out_valid, and all out_* payload and flags.
- REQ-033: A reset during REQ, WAIT, SEND or EMPTY SHALL drop the in-flight vertex.
- REQ-034: A response arriving after reset release SHALL be ignored.

Verification
- REQ-035: Vertex id=5, addr=0x1000, num_edges=3, memory 1-cycle latency, out_ready=1 -> requests to 0x1000, 0x1010, 0x1020; outputs edge_id 0,1,2; last_edge only on edge_id 2; in_ready returns 1 afterwards.
- REQ-036: num_edges=0, last_vertex=1 -> single record with edges_empty=1, last_edge=1, last_vertex=1, dst_id=0; no mem_req_valid.
- REQ-037: mem_req_ready held 0 for 4 cycles, then out_ready held 0 for 3 cycles -> mem_req_addr stable while stalled; out_* stable while stalled; exactly one output per edge.
- REQ-038: addr=2^64-16, num_edges=2 -> second request address 0x0 (wrap).
- REQ-039: reset=0 asserted in WAIT, then a stray mem_rsp_valid after release -> outputs 0 during reset, state IDLE, no out_valid; the next vertex is processed correctly.
- REQ-040: Spurious mem_rsp_valid while in IDLE or SEND -> no change to outputs or state.
